// File: rtl/rvi_slt_operand_issue.sv
// rvi_slt_operand_issue
//
// Operand-issue stage for the RV integer set-less-than execute unit.
// Decodes SLT/SLTU/SLTI/SLTIU from an accepted instruction word, forms
// operand 2 from rs2 or the sign-extended I-immediate, and presents the
// SLT execute interface (en/s1/s2/unsignedFlg) plus rd from registers.
//
// Build option: define RVI_SLT_ISSUE_SKID_EN to add a skid entry behind the
// output register. inReady then becomes a register, which removes the
// combinational outReady -> inReady path. Without it a single output
// register is used and inReady = ~sltEn | outReady.
//
// Handshake (both ports): a beat transfers on a rising clk edge where its
// valid and ready are both 1. The producer holds valid and the payload stable
// until that edge, and valid never depends on ready. flush=1 at an edge
// cancels any transfer on that edge, on either port.
//
// The FSM state (EMPTY=0, ONE=1, TWO=2 beats held) is visible on dbgState.

module rvi_slt_operand_issue #(
    parameter int  RV64      = 0,
    localparam int CPU_WIDTH = 32 * (RV64 + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 inValid,
    output logic                 inReady,
    input  logic [31:0]          inInstr,
    input  logic [CPU_WIDTH-1:0] inRs1Data,
    input  logic [CPU_WIDTH-1:0] inRs2Data,
    input  logic                 outReady,
    output logic                 sltEn,
    output logic [CPU_WIDTH-1:0] sltS1,
    output logic [CPU_WIDTH-1:0] sltS2,
    output logic                 sltUnsignedFlg,
    output logic [4:0]           sltRd,
    output logic                 decErr,
    output logic [1:0]           dbgState
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [CPU_WIDTH-1:0] s1;
        logic [CPU_WIDTH-1:0] s2;
        logic                 uns;
        logic [4:0]           rd;
    } beat_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       funct3Slt;
    logic       isSltReg;
    logic       isSltImm;
    logic       isSlt;
    // The rs1 index field is not needed: register data arrives already read.
    logic       unusedRs1Field;

    assign opcode         = inInstr[6:0];
    assign funct3         = inInstr[14:12];
    assign funct7         = inInstr[31:25];
    assign unusedRs1Field = ^inInstr[19:15];

    // funct3 010 (signed) and 011 (unsigned) are the only SLT encodings.
    assign funct3Slt = (funct3[2:1] == 2'b01);
    assign isSltReg  = (opcode == OPC_OP) && (funct7 == 7'b0000000) && funct3Slt;
    assign isSltImm  = (opcode == OPC_OP_IMM) && funct3Slt;
    assign isSlt     = isSltReg | isSltImm;

    beat_t inBeat;

    // Build the issue payload; SLTIU also sign-extends its immediate.
    always_comb begin
        inBeat.s1  = inRs1Data;
        inBeat.s2  = isSltImm ? {{(CPU_WIDTH-12){inInstr[31]}}, inInstr[31:20]}
                              : inRs2Data;
        inBeat.uns = funct3[0];
        inBeat.rd  = inInstr[11:7];
    end

    // ------------------------------------------------------------------
    // Handshake events
    // ------------------------------------------------------------------
    logic accept;
    logic push;
    logic pop;

    assign accept = inValid & inReady & ~flush;
    assign push   = accept & isSlt;
    // A pop on a flush edge is discarded by the flush branch of the FSM.
    assign pop    = sltEn & outReady;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    state_t state;
    state_t stateNext;
    logic   loadOut;
`ifdef RVI_SLT_ISSUE_SKID_EN
    logic   loadSkid;
    logic   skidToOut;
`endif

    // State register; sltEn and decErr are registered alongside it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= EMPTY;
            sltEn  <= 1'b0;
            decErr <= 1'b0;
        end else begin
            state  <= stateNext;
            sltEn  <= (stateNext != EMPTY);
            decErr <= accept & ~isSlt;
        end
    end

    // Next-state and storage load enables.
    always_comb begin
        stateNext = state;
        loadOut   = 1'b0;
`ifdef RVI_SLT_ISSUE_SKID_EN
        loadSkid  = 1'b0;
        skidToOut = 1'b0;
`endif
        if (flush) begin
            stateNext = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        stateNext = ONE;
                        loadOut   = 1'b1;
                    end
                end
                ONE: begin
`ifdef RVI_SLT_ISSUE_SKID_EN
                    if (push && pop) begin
                        loadOut = 1'b1;
                    end else if (push) begin
                        stateNext = TWO;
                        loadSkid  = 1'b1;
                    end else if (pop) begin
                        stateNext = EMPTY;
                    end
`else
                    // Without a skid entry, push in ONE implies pop.
                    if (push) begin
                        loadOut = 1'b1;
                    end else if (pop) begin
                        stateNext = EMPTY;
                    end
`endif
                end
`ifdef RVI_SLT_ISSUE_SKID_EN
                TWO: begin
                    if (pop) begin
                        stateNext = ONE;
                        skidToOut = 1'b1;
                    end
                end
`endif
                default: begin
                    stateNext = EMPTY;
                end
            endcase
        end
    end

    assign dbgState = state;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    beat_t outBeat;

`ifdef RVI_SLT_ISSUE_SKID_EN
    beat_t skidBeat;
    logic  inReadyQ;

    // Output register: new beat, or the skid entry moving forward.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outBeat <= '0;
        end else if (loadOut) begin
            outBeat <= inBeat;
        end else if (skidToOut) begin
            outBeat <= skidBeat;
        end
    end

    // Skid entry captures a beat that arrives while the output is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skidBeat <= '0;
        end else if (loadSkid) begin
            skidBeat <= inBeat;
        end
    end

    // Registered ready: low only while both entries are full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inReadyQ <= 1'b1;
        end else begin
            inReadyQ <= (stateNext != TWO);
        end
    end

    assign inReady = inReadyQ;
`else
    // Output register loads whenever a decoded SLT beat is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outBeat <= '0;
        end else if (loadOut) begin
            outBeat <= inBeat;
        end
    end

    assign inReady = ~sltEn | outReady;
`endif

    assign sltS1          = outBeat.s1;
    assign sltS2          = outBeat.s2;
    assign sltUnsignedFlg = outBeat.uns;
    assign sltRd          = outBeat.rd;

endmodule

// File: tb/tb_rvi_slt_operand_issue.sv
// Testbench for rvi_slt_operand_issue (RV32 build). Honours
// RVI_SLT_ISSUE_SKID_EN for the expected inReady/backpressure behaviour.

module tb_rvi_slt_operand_issue;

    localparam int W  = 32;
    localparam int PW = 2 * W + 6;

`ifdef RVI_SLT_ISSUE_SKID_EN
    localparam int EXP_STALL_ACC = 2;
`else
    localparam int EXP_STALL_ACC = 1;
`endif

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          inValid;
    logic          inReady;
    logic [31:0]   inInstr;
    logic [W-1:0]  inRs1Data;
    logic [W-1:0]  inRs2Data;
    logic          outReady;
    logic          sltEn;
    logic [W-1:0]  sltS1;
    logic [W-1:0]  sltS2;
    logic          sltUnsignedFlg;
    logic [4:0]    sltRd;
    logic          decErr;
    logic [1:0]    dbgState;

    always #5 clk = ~clk;

    rvi_slt_operand_issue #(.RV64(0)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .inValid        (inValid),
        .inReady        (inReady),
        .inInstr        (inInstr),
        .inRs1Data      (inRs1Data),
        .inRs2Data      (inRs2Data),
        .outReady       (outReady),
        .sltEn          (sltEn),
        .sltS1          (sltS1),
        .sltS2          (sltS2),
        .sltUnsignedFlg (sltUnsignedFlg),
        .sltRd          (sltRd),
        .decErr         (decErr),
        .dbgState       (dbgState)
    );

    // ---------------- vectors ----------------
    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        bit          is_slt;
        logic [31:0] s2;
        bit          uns;
        logic [4:0]  rd;
    } vec_t;

    vec_t vecs[11];

    // ---------------- scoreboard ----------------
    logic [PW-1:0] exp_q[$];
    int            tests = 0;
    int            fails = 0;
    bit            exp_dec = 1'b0;
    bit            cur_slt = 1'b0;
    logic [PW-1:0] cur_pl = '0;
    bit            accepted = 1'b0;
    bit            rand_ready = 1'b0;

    task automatic check(input string name, input logic [PW-1:0] act,
                         input logic [PW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic bit exp_ready();
`ifdef RVI_SLT_ISSUE_SKID_EN
        return exp_q.size() < 2;
`else
        return (exp_q.size() == 0) || (outReady == 1'b1);
`endif
    endfunction

    // ---------------- driver tasks ----------------
    task automatic present(input vec_t v);
        inValid   = 1'b1;
        inInstr   = v.instr;
        inRs1Data = v.rs1;
        inRs2Data = v.rs2;
        cur_slt   = v.is_slt;
        cur_pl    = {v.rs1, v.s2, v.uns, v.rd};
    endtask

    // One clock: compare outputs mid-cycle, then model the coming edge.
    task automatic tick();
        bit acc;
        bit pop;
        @(negedge clk);
        check("sltEn", PW'(sltEn), PW'(exp_q.size() != 0));
        check("inReady", PW'(inReady), PW'(exp_ready()));
        check("decErr", PW'(decErr), PW'(exp_dec));
        check("dbgState", PW'(dbgState), PW'(exp_q.size()));
        if (exp_q.size() != 0)
            check("payload", {sltS1, sltS2, sltUnsignedFlg, sltRd}, exp_q[0]);
        acc = inValid && exp_ready() && !flush;
        pop = (exp_q.size() != 0) && outReady && !flush;
        if (flush) begin
            exp_q.delete();
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (acc && cur_slt) exp_q.push_back(cur_pl);
        end
        exp_dec  = acc && !cur_slt;
        accepted = acc;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input vec_t v, output int n);
        present(v);
        accepted = 1'b0;
        n = 0;
        while (!accepted && n < 40) begin
            if (rand_ready) outReady = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        check("send_accepted", PW'(accepted), PW'(1));
        inValid = 1'b0;
    endtask

    task automatic drain();
        outReady = 1'b1;
        for (int i = 0; i < 40 && (exp_q.size() != 0 || exp_dec); i++) tick();
        if (exp_q.size() != 0) check("drain_timeout", PW'(exp_q.size()), '0);
        check("drain_idle", PW'(sltEn), '0);
    endtask

    // ---------------- test ----------------
    initial begin
        int   n;
        int   k;
        vec_t abc[3];

        vecs[0]  = '{32'h0020A1B3, 32'hFFFFFFFF, 32'h00000001, 1'b1, 32'h00000001, 1'b0, 5'd3};  // SLT x3,x1,x2
        vecs[1]  = '{32'hFFF33293, 32'h00000007, 32'h12345678, 1'b1, 32'hFFFFFFFF, 1'b1, 5'd5};  // SLTIU x5,x6,-1
        vecs[2]  = '{32'h00C5B533, 32'h80000000, 32'h7FFFFFFF, 1'b1, 32'h7FFFFFFF, 1'b1, 5'd10}; // SLTU x10,x11,x12
        vecs[3]  = '{32'h7FF02F93, 32'h00000000, 32'hDEADBEEF, 1'b1, 32'h000007FF, 1'b0, 5'd31}; // SLTI x31,x0,2047
        vecs[4]  = '{32'h80012093, 32'h55555555, 32'hAAAAAAAA, 1'b1, 32'hFFFFF800, 1'b0, 5'd1};  // SLTI x1,x2,-2048
        vecs[5]  = '{32'h002081B3, 32'h00000001, 32'h00000002, 1'b0, 32'h0, 1'b0, 5'd0};         // ADD
        vecs[6]  = '{32'h4020A1B3, 32'h00000001, 32'h00000002, 1'b0, 32'h0, 1'b0, 5'd0};         // funct7 0100000
        vecs[7]  = '{32'h00500093, 32'h00000003, 32'h00000004, 1'b0, 32'h0, 1'b0, 5'd0};         // ADDI
        vecs[8]  = '{32'h00003013, 32'hCAFEF00D, 32'h0BADF00D, 1'b1, 32'h00000000, 1'b1, 5'd0};  // SLTIU x0,x0,0
        vecs[9]  = '{32'h0220B1B3, 32'h00000009, 32'h0000000A, 1'b0, 32'h0, 1'b0, 5'd0};         // MULHU
        vecs[10] = '{32'h0000A183, 32'h00000011, 32'h00000022, 1'b0, 32'h0, 1'b0, 5'd0};         // LW

        rst = 1'b1; flush = 1'b0; inValid = 1'b0; inInstr = '0;
        inRs1Data = '0; inRs2Data = '0; outReady = 1'b1;

        // Reset values before any clock edge.
        #1;
        check("rst_sltEn", PW'(sltEn), '0);
        check("rst_payload", {sltS1, sltS2, sltUnsignedFlg, sltRd}, '0);
        check("rst_decErr", PW'(decErr), '0);
        check("rst_inReady", PW'(inReady), PW'(1));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Table pass, downstream always ready.
        for (int i = 0; i < 11; i++) send(vecs[i], n);
        drain();

        // Back-to-back throughput with random backpressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 30; i++) send(vecs[$urandom_range(0, 10)], n);
        rand_ready = 1'b0;
        drain();

        // ADD: no beat, decErr one cycle.
        send(vecs[5], n);
        check("add_decErr_hi", PW'(decErr), PW'(1));
        check("add_no_beat", PW'(sltEn), '0);
        tick();
        check("add_decErr_lo", PW'(decErr), '0);

        // Backpressure: A, B, C on consecutive cycles with outReady low.
        abc[0] = vecs[0]; abc[1] = vecs[1]; abc[2] = vecs[2];
        k = 0;
        for (int c = 0; c < 30 && (k < 3 || exp_q.size() != 0); c++) begin
            outReady = (c >= 5);
            if (k < 3) present(abc[k]);
            else inValid = 1'b0;
            tick();
            if (accepted) k++;
            if (c == 3) check("stall_accepts", PW'(k), PW'(EXP_STALL_ACC));
        end
        inValid = 1'b0;
        check("stall_all_accepted", PW'(k), PW'(3));
        drain();

        // Flush with a stalled beat and a simultaneous accepted SLT.
        outReady = 1'b0;
        send(vecs[0], n);
        outReady = 1'b1;
        present(vecs[3]);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        inValid = 1'b0;
        check("flush_sltEn", PW'(sltEn), '0);
        check("flush_decErr", PW'(decErr), '0);
        check("flush_inReady", PW'(inReady), PW'(1));
        tick();

        // Flush with a non-SLT on the input: no decErr.
        present(vecs[5]);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        inValid = 1'b0;
        check("flush_add_decErr", PW'(decErr), '0);
        tick();

        // Asynchronous reset while a beat is stalled.
        outReady = 1'b0;
        send(vecs[1], n);
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("arst_sltEn", PW'(sltEn), '0);
        check("arst_payload", {sltS1, sltS2, sltUnsignedFlg, sltRd}, '0);
        check("arst_decErr", PW'(decErr), '0);
        check("arst_inReady", PW'(inReady), PW'(1));
        exp_q.delete();
        exp_dec = 1'b0;
        rst = 1'b0;
        outReady = 1'b1;
        send(vecs[4], n);
        check("arst_first_edge_accept", PW'(n), PW'(1));
        check("arst_sltEn_after", PW'(sltEn), PW'(1));
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
